// File: rtl/clock_date_pkg.sv
// ============================================================================
// Module   : clock_date_pkg
// Purpose  : Shared constants and state encoding for the day/month clock stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_date_pkg;

   localparam logic [3:0] DEF_DAY_TENS_SEL    = 4'd6;
   localparam logic [3:0] DEF_DAY_UNITS_SEL   = 4'd7;
   localparam logic [3:0] DEF_MONTH_TENS_SEL  = 4'd8;
   localparam logic [3:0] DEF_MONTH_UNITS_SEL = 4'd9;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      SET   = 2'd1,
      FIXUP = 2'd2
   } date_state_e;

   // Month lengths held as two BCD digits so they compare directly with the date
   localparam logic [7:0] LEN_28 = 8'h28;
   localparam logic [7:0] LEN_29 = 8'h29;
   localparam logic [7:0] LEN_30 = 8'h30;
   localparam logic [7:0] LEN_31 = 8'h31;

   localparam logic [7:0] RST_DAY   = 8'h01;
   localparam logic [7:0] RST_MONTH = 8'h01;

endpackage

`default_nettype wire

// File: rtl/clock_month_length.sv
// ============================================================================
// Module   : clock_month_length
// Purpose  : BCD month in, BCD number of days in that month out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_month_length
   import clock_date_pkg::*;
(
   input  logic [7:0] month_i,
   input  logic       leap_i,
   output logic [7:0] length_o
);

   always_comb begin
      length_o = LEN_30;
      case (month_i)
         8'h01, 8'h03, 8'h05, 8'h07,
         8'h08, 8'h10, 8'h12: length_o = LEN_31;
         8'h02:               length_o = leap_i ? LEN_29 : LEN_28;
         default:             length_o = LEN_30;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/clock_date_ddmm.sv
// ============================================================================
// Module   : clock_date_ddmm
// Purpose  : BCD day/month calendar stage with keypad set mode and year pulse.
//            Macro CLOCK_DATE_LEAP_YEAR_EN enables 29-day February in leap years.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_date_ddmm
   import clock_date_pkg::*;
#(
   parameter logic [3:0] DAY_TENS_SEL    = DEF_DAY_TENS_SEL,
   parameter logic [3:0] DAY_UNITS_SEL   = DEF_DAY_UNITS_SEL,
   parameter logic [3:0] MONTH_TENS_SEL  = DEF_MONTH_TENS_SEL,
   parameter logic [3:0] MONTH_UNITS_SEL = DEF_MONTH_UNITS_SEL
)(
   input  logic       CLK_for_date,
   input  logic       RST_n,
   input  logic       day_tick,
   input  logic [3:0] year_decade,
   input  logic [3:0] year_unit,
   input  logic       set_time_enable,
   input  logic [3:0] set_digit_sel,
   input  logic [3:0] set_value,
   input  logic       set_strobe,
   output logic [3:0] day_tens,
   output logic [3:0] day_units,
   output logic [3:0] month_tens,
   output logic [3:0] month_units,
   output logic       pulse_to_year
);

   date_state_e state_q, state_d;
   logic [3:0]  day_tens_q, day_tens_d, day_units_q, day_units_d;
   logic [3:0]  month_tens_q, month_tens_d, month_units_q, month_units_d;
   logic        pulse_q, pulse_d;

   logic [7:0]  day_cur, month_cur, month_clamp, month_len;
   logic        leap_year;
   logic        unused_year;

`ifdef CLOCK_DATE_LEAP_YEAR_EN
   assign leap_year = year_decade[0] ? (year_unit == 4'd2 || year_unit == 4'd6)
                                     : (year_unit == 4'd0 || year_unit == 4'd4 ||
                                        year_unit == 4'd8);
   assign unused_year = ^year_decade[3:1];
`else
   assign leap_year   = 1'b0;
   assign unused_year = ^{year_decade, year_unit};
`endif

   assign day_cur   = {day_tens_q, day_units_q};
   assign month_cur = {month_tens_q, month_units_q};

   // Identity for any legal month, so RUN and FIXUP share one length lookup
   always_comb begin
      month_clamp = month_cur;
      if (month_cur == 8'h00)
         month_clamp = 8'h01;
      else if (month_cur > 8'h12)
         month_clamp = 8'h12;
   end

   clock_month_length u_month_length (
      .month_i  (month_clamp),
      .leap_i   (leap_year),
      .length_o (month_len)
   );

   always_comb begin
      state_d       = state_q;
      day_tens_d    = day_tens_q;
      day_units_d   = day_units_q;
      month_tens_d  = month_tens_q;
      month_units_d = month_units_q;
      pulse_d       = 1'b0;
      case (state_q)
         RUN: begin
            if (set_time_enable) begin
               state_d = SET;
            end else if (day_tick) begin
               if (day_cur < month_len) begin
                  if (day_units_q == 4'd9) begin
                     day_units_d = 4'd0;
                     day_tens_d  = day_tens_q + 4'd1;
                  end else begin
                     day_units_d = day_units_q + 4'd1;
                  end
               end else begin
                  {day_tens_d, day_units_d} = 8'h01;
                  if (month_cur == 8'h12) begin
                     {month_tens_d, month_units_d} = 8'h01;
                     pulse_d = 1'b1;
                  end else if (month_units_q == 4'd9) begin
                     month_units_d = 4'd0;
                     month_tens_d  = month_tens_q + 4'd1;
                  end else begin
                     month_units_d = month_units_q + 4'd1;
                  end
               end
            end
         end
         SET: begin
            if (set_strobe && set_value <= 4'd9) begin
               if (set_digit_sel == DAY_TENS_SEL)    day_tens_d    = set_value;
               if (set_digit_sel == DAY_UNITS_SEL)   day_units_d   = set_value;
               if (set_digit_sel == MONTH_TENS_SEL)  month_tens_d  = set_value;
               if (set_digit_sel == MONTH_UNITS_SEL) month_units_d = set_value;
            end
            if (!set_time_enable) state_d = FIXUP;
         end
         FIXUP: begin
            {month_tens_d, month_units_d} = month_clamp;
            if (day_cur == 8'h00)
               {day_tens_d, day_units_d} = 8'h01;
            else if (day_cur > month_len)
               {day_tens_d, day_units_d} = month_len;
            state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge CLK_for_date) begin
      if (!RST_n) begin
         state_q       <= RUN;
         day_tens_q    <= RST_DAY[7:4];
         day_units_q   <= RST_DAY[3:0];
         month_tens_q  <= RST_MONTH[7:4];
         month_units_q <= RST_MONTH[3:0];
         pulse_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         day_tens_q    <= day_tens_d;
         day_units_q   <= day_units_d;
         month_tens_q  <= month_tens_d;
         month_units_q <= month_units_d;
         pulse_q       <= pulse_d;
      end
   end

   assign day_tens      = day_tens_q;
   assign day_units     = day_units_q;
   assign month_tens    = month_tens_q;
   assign month_units   = month_units_q;
   assign pulse_to_year = pulse_q;

endmodule

`default_nettype wire
